// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// common / pipes : shared constants and pipeline control types
// Revision 1.0
// -----------------------------------------------------------------------------
package common;
   localparam int NREG_DEFAULT       = 32;
   localparam int MULDIV_LAT_DEFAULT = 64;
endpackage

package pipes;
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_ALU  = 2'b01,
      FWD_WB   = 2'b10
   } forwarding_control;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      DRAIN       = 2'b01,
      WAIT_COMMIT = 2'b10
   } csr_state_t;
endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_scoreboard.sv
`default_nettype none
// -----------------------------------------------------------------------------
// reg_scoreboard : per-register 2-bit counts of in-flight writes (x0 untracked)
// Revision 1.0
// -----------------------------------------------------------------------------
module reg_scoreboard #(
   parameter int NREG = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_en,
   input  logic [4:0] inc_idx,
   input  logic       dec_en,
   input  logic [4:0] dec_idx,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   output logic       busy1,
   output logic       busy2,
   output logic       single1,
   output logic       single2,
   output logic       any_pend
);

   logic [NREG-1:0][1:0] w_pend;

   assign w_pend[0] = 2'b00;

   genvar r;
   for (r = 1; r < NREG; r++) begin : g_pend
      logic [1:0] r_cnt;
      logic       w_inc;
      logic       w_dec;

      assign w_inc = inc_en && (inc_idx == 5'(r));
      assign w_dec = dec_en && (dec_idx == 5'(r));

      // A same-cycle issue and commit to one register cancel out.
      always_ff @(posedge clk) begin
         if (reset)
            r_cnt <= 2'd0;
         else if (w_inc && !w_dec)
            r_cnt <= r_cnt + 2'd1;
         else if (w_dec && !w_inc)
            r_cnt <= r_cnt - 2'd1;
      end

      assign w_pend[r] = r_cnt;
   end

   assign busy1    = (w_pend[rs1] != 2'd0);
   assign busy2    = (w_pend[rs2] != 2'd0);
   assign single1  = (w_pend[rs1] == 2'd1);
   assign single2  = (w_pend[rs2] == 2'd1);
   assign any_pend = |w_pend;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// hazard_ctrl : decode-stage stall/forward control, mul/div hold, CSR serialiser
// Revision 1.0
// -----------------------------------------------------------------------------
module hazard_ctrl
   import common::*;
   import pipes::*;
#(
   parameter int NREG       = NREG_DEFAULT,
   parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [4:0]        d_rs1,
   input  logic [4:0]        d_rs2,
   input  logic              d_use_rs1,
   input  logic              d_use_rs2,
   input  logic              d_regwrite,
   input  logic [4:0]        d_dst,
   input  logic              d_is_csr,
   input  logic              ex_muldiv_start,
   input  logic              ex_branch_flush,
   input  logic              wb_valid,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_dst,
   input  logic              wb_is_csr,
   output logic              stall,
   output logic              stall_ex,
   output logic              flush_d,
   output forwarding_control forwardingAA,
   output forwarding_control forwardingBB,
   output logic              issue
);

   localparam int             CW          = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
   localparam logic [CW-1:0]  C_BUSY_LOAD = CW'(MULDIV_LAT - 1);

   csr_state_t    r_state;
   logic [CW-1:0] r_busy_cnt;

   logic w_busy1, w_busy2, w_single1, w_single2, w_any_pend;
   logic w_wb_write, w_haz1, w_haz2, w_fwd1, w_fwd2;
   logic w_csr_enter, w_csr_block, w_stall_raw, w_busy_ex, w_issue;

   assign w_wb_write = wb_valid && wb_regwrite && (wb_dst != 5'd0);

   reg_scoreboard #(.NREG(NREG)) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .inc_en   (w_issue && d_regwrite && (d_dst != 5'd0)),
      .inc_idx  (d_dst),
      .dec_en   (w_wb_write),
      .dec_idx  (wb_dst),
      .rs1      (d_rs1),
      .rs2      (d_rs2),
      .busy1    (w_busy1),
      .busy2    (w_busy2),
      .single1  (w_single1),
      .single2  (w_single2),
      .any_pend (w_any_pend)
   );

   // Forwarding from WB only covers the last outstanding write to a source.
   assign w_haz1 = d_use_rs1 && (d_rs1 != 5'd0) && w_busy1;
   assign w_haz2 = d_use_rs2 && (d_rs2 != 5'd0) && w_busy2;
   assign w_fwd1 = w_haz1 && w_single1 && wb_valid && wb_regwrite && (wb_dst == d_rs1);
   assign w_fwd2 = w_haz2 && w_single2 && wb_valid && wb_regwrite && (wb_dst == d_rs2);

   assign w_csr_enter = d_valid && d_is_csr && w_any_pend;

   // DRAIN releases the CSR as soon as every older write has committed.
   always_comb begin
      w_csr_block = 1'b0;
      case (r_state)
         IDLE:        w_csr_block = w_csr_enter;
         DRAIN:       w_csr_block = w_any_pend;
         WAIT_COMMIT: w_csr_block = d_valid;
         default:     w_csr_block = 1'b0;
      endcase
   end

   assign w_stall_raw = (w_haz1 && !w_fwd1) || (w_haz2 && !w_fwd2) || w_csr_block;
   assign w_busy_ex   = (r_busy_cnt != '0);
   assign w_issue     = !reset && d_valid && !w_stall_raw && !w_busy_ex && !ex_branch_flush;

   assign stall        = !reset && w_stall_raw;
   assign stall_ex     = !reset && w_busy_ex;
   assign flush_d      = ex_branch_flush;
   assign issue        = w_issue;
   assign forwardingAA = (!reset && w_fwd1) ? FWD_WB : FWD_NONE;
   assign forwardingBB = (!reset && w_fwd2) ? FWD_WB : FWD_NONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue && d_is_csr)
                  r_state <= WAIT_COMMIT;
               else if (w_csr_enter && !ex_branch_flush)
                  r_state <= DRAIN;
            end
            DRAIN: begin
               if (ex_branch_flush)
                  r_state <= IDLE;
               else if (w_issue && d_is_csr)
                  r_state <= WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
               if (wb_valid && wb_is_csr)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_busy_cnt <= '0;
      else if (ex_muldiv_start)
         r_busy_cnt <= C_BUSY_LOAD;
      else if (w_busy_ex)
         r_busy_cnt <= r_busy_cnt - 1'b1;
   end

endmodule
`default_nettype wire
